// File: rtl/dec_vp_pkg.sv
// Shared types and helpers for the dec value-prediction flush arbiter slice.
// Optional statistics outputs are enabled with the DEC_VP_FLUSH_STATS_EN macro.
package dec_vp_pkg;

    localparam int PATH_W   = 63;
    localparam int RESULT_W = 64;

    typedef enum logic [1:0] {
        VP_IDLE,
        VP_FLUSH,
        VP_RECOVER
    } vp_arb_state_t;

    typedef enum logic {
        VP_LANE_I0,
        VP_LANE_I1
    } vp_lane_t;

    typedef struct packed {
        logic [PATH_W-1:0]   path;
        logic [RESULT_W-1:0] result;
        vp_lane_t            lane;
    } vp_flush_pkt_t;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dec_vp_flush_arb_if.sv
// Request/flush bundle between the per-lane VP checks, the arbiter and the flush mux.
// The statistics counters exist only when DEC_VP_FLUSH_STATS_EN is defined.
interface dec_vp_flush_arb_if;
    import dec_vp_pkg::*;

    logic                freeze;
    logic                ext_flush;
    logic                i0_vp_req;
    logic [PATH_W-1:0]   i0_vp_path;
    logic [RESULT_W-1:0] i0_vp_actual;
    logic                i1_vp_req;
    logic [PATH_W-1:0]   i1_vp_path;
    logic [RESULT_W-1:0] i1_vp_actual;
    logic                vp_flush_valid;
    logic [PATH_W-1:0]   vp_flush_path;
    logic [RESULT_W-1:0] vp_flush_result;
    logic                vp_flush_lane;
    logic                vp_busy;
    logic                vp_disable;
`ifdef DEC_VP_FLUSH_STATS_EN
    logic [31:0]         vp_stat_flushes;
    logic [31:0]         vp_stat_disables;

    modport master (
        output freeze, ext_flush,
        output i0_vp_req, i0_vp_path, i0_vp_actual,
        output i1_vp_req, i1_vp_path, i1_vp_actual,
        input  vp_flush_valid, vp_flush_path, vp_flush_result, vp_flush_lane,
        input  vp_busy, vp_disable, vp_stat_flushes, vp_stat_disables
    );

    modport slave (
        input  freeze, ext_flush,
        input  i0_vp_req, i0_vp_path, i0_vp_actual,
        input  i1_vp_req, i1_vp_path, i1_vp_actual,
        output vp_flush_valid, vp_flush_path, vp_flush_result, vp_flush_lane,
        output vp_busy, vp_disable, vp_stat_flushes, vp_stat_disables
    );
`else
    modport master (
        output freeze, ext_flush,
        output i0_vp_req, i0_vp_path, i0_vp_actual,
        output i1_vp_req, i1_vp_path, i1_vp_actual,
        input  vp_flush_valid, vp_flush_path, vp_flush_result, vp_flush_lane,
        input  vp_busy, vp_disable
    );

    modport slave (
        input  freeze, ext_flush,
        input  i0_vp_req, i0_vp_path, i0_vp_actual,
        input  i1_vp_req, i1_vp_path, i1_vp_actual,
        output vp_flush_valid, vp_flush_path, vp_flush_result, vp_flush_lane,
        output vp_busy, vp_disable
    );
`endif

endinterface

// File: rtl/dec_vp_throttle.sv
// Mispredict-rate throttle: counts accepted VP flushes per observation window
// and raises vp_disable for a fixed number of cycles once the threshold is hit.
module dec_vp_throttle
    import dec_vp_pkg::*;
#(
    parameter int WIN_CYC = 64,
    parameter int THRESH  = 8,
    parameter int DIS_CYC = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic freeze,
    input  logic accept,
    output logic vp_disable
);

    localparam int WIN_W = cnt_w(WIN_CYC - 1);
    localparam int HIT_W = cnt_w(THRESH);
    localparam int DIS_W = cnt_w(DIS_CYC - 1);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
    localparam logic [HIT_W-1:0] HIT_TRIP = HIT_W'(THRESH);
    localparam logic [DIS_W-1:0] DIS_LOAD = DIS_W'(DIS_CYC - 1);

    logic [WIN_W-1:0] win_cnt;
    logic [HIT_W-1:0] hit_cnt;
    logic [DIS_W-1:0] dis_cnt;
    logic             win_wrap;
    logic [HIT_W-1:0] hit_base;
    logic [HIT_W-1:0] hit_inc;
    logic             trip;

    // Window wrap clears the hit count first, so an acceptance in the wrap cycle counts as one.
    always_comb begin
        win_wrap = (win_cnt == WIN_LAST);
        hit_base = win_wrap ? '0 : hit_cnt;
        hit_inc  = (hit_base == HIT_TRIP) ? hit_base : hit_base + 1'b1;
        trip     = accept & (hit_inc == HIT_TRIP);
    end

    // Window, hit and disable counters; everything holds under freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt    <= '0;
            hit_cnt    <= '0;
            dis_cnt    <= '0;
            vp_disable <= 1'b0;
        end else if (!freeze) begin
            if (vp_disable) begin
                win_cnt <= '0;
                hit_cnt <= '0;
                if (dis_cnt == '0) begin
                    vp_disable <= 1'b0;
                end else begin
                    dis_cnt <= dis_cnt - 1'b1;
                end
            end else if (trip) begin
                vp_disable <= 1'b1;
                dis_cnt    <= DIS_LOAD;
                win_cnt    <= '0;
                hit_cnt    <= '0;
            end else begin
                win_cnt <= win_wrap ? '0 : win_cnt + 1'b1;
                hit_cnt <= accept ? hit_inc : hit_base;
            end
        end
    end

endmodule

// File: rtl/dec_vp_flush_arb.sv
// VP mispredict flush arbiter: picks the older lane, emits one registered flush
// per recovery episode, blocks further flushes while the front end refills, and
// throttles value prediction when mispredicts are too frequent.
// Defining DEC_VP_FLUSH_STATS_EN adds flush and disable event counters.
module dec_vp_flush_arb
    import dec_vp_pkg::*;
#(
    parameter int RECOVER_CYC = 4,
    parameter int WIN_CYC     = 64,
    parameter int THRESH      = 8,
    parameter int DIS_CYC     = 256
) (
    input  logic               clk,
    input  logic               rst,
    dec_vp_flush_arb_if.slave  bus
);

    localparam int REC_W = cnt_w(RECOVER_CYC - 1);
    localparam logic [REC_W-1:0] REC_LOAD = REC_W'(RECOVER_CYC - 1);

    vp_arb_state_t   state_q;
    vp_arb_state_t   state_d;
    logic [REC_W-1:0] rec_cnt_q;
    logic [REC_W-1:0] rec_cnt_d;
    logic            accept;
    vp_flush_pkt_t   pkt_sel;
    vp_flush_pkt_t   pkt_p1;

    // A request is taken only from an idle, unfrozen arbiter with no competing external flush.
    always_comb begin
        accept = (state_q == VP_IDLE) & ~bus.freeze & ~bus.ext_flush
               & (bus.i0_vp_req | bus.i1_vp_req);
    end

    // i0 is the older instruction, so it wins; a simultaneous i1 request is simply dropped.
    always_comb begin
        pkt_sel = '0;
        if (bus.i0_vp_req) begin
            pkt_sel.path   = bus.i0_vp_path;
            pkt_sel.result = bus.i0_vp_actual;
            pkt_sel.lane   = VP_LANE_I0;
        end else begin
            pkt_sel.path   = bus.i1_vp_path;
            pkt_sel.result = bus.i1_vp_actual;
            pkt_sel.lane   = VP_LANE_I1;
        end
    end

    // Next-state logic: freeze holds everything, an external flush returns to idle.
    always_comb begin
        state_d   = state_q;
        rec_cnt_d = rec_cnt_q;
        if (bus.freeze) begin
            state_d   = state_q;
            rec_cnt_d = rec_cnt_q;
        end else if (bus.ext_flush) begin
            state_d   = VP_IDLE;
            rec_cnt_d = '0;
        end else begin
            case (state_q)
                VP_IDLE: begin
                    if (accept) begin
                        state_d = VP_FLUSH;
                    end
                end
                VP_FLUSH: begin
                    state_d   = VP_RECOVER;
                    rec_cnt_d = REC_LOAD;
                end
                VP_RECOVER: begin
                    if (rec_cnt_q == '0) begin
                        state_d = VP_IDLE;
                    end else begin
                        rec_cnt_d = rec_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d   = VP_IDLE;
                    rec_cnt_d = '0;
                end
            endcase
        end
    end

    // FSM state and recovery counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= VP_IDLE;
            rec_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rec_cnt_q <= rec_cnt_d;
        end
    end

    // Flush packet captured at acceptance and held until the next acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_p1 <= '0;
        end else if (accept) begin
            pkt_p1 <= pkt_sel;
        end
    end

    // Pulse leaves from the FLUSH state, masked by a same-cycle external flush or freeze.
    always_comb begin
        bus.vp_flush_valid  = (state_q == VP_FLUSH) & ~bus.ext_flush & ~bus.freeze;
        bus.vp_flush_path   = pkt_p1.path;
        bus.vp_flush_result = pkt_p1.result;
        bus.vp_flush_lane   = (pkt_p1.lane == VP_LANE_I1);
        bus.vp_busy         = (state_q != VP_IDLE);
    end

    logic vp_disable_int;

    dec_vp_throttle #(
        .WIN_CYC (WIN_CYC),
        .THRESH  (THRESH),
        .DIS_CYC (DIS_CYC)
    ) u_throttle (
        .clk        (clk),
        .rst        (rst),
        .freeze     (bus.freeze),
        .accept     (accept),
        .vp_disable (vp_disable_int)
    );

    always_comb bus.vp_disable = vp_disable_int;

`ifdef DEC_VP_FLUSH_STATS_EN
    logic [31:0] stat_flushes_q;
    logic [31:0] stat_disables_q;
    logic        dis_seen_q;

    // Event counters; the disable edge detector only advances when not frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_flushes_q  <= '0;
            stat_disables_q <= '0;
            dis_seen_q      <= 1'b0;
        end else if (!bus.freeze) begin
            dis_seen_q <= vp_disable_int;
            if (bus.vp_flush_valid) begin
                stat_flushes_q <= stat_flushes_q + 32'd1;
            end
            if (vp_disable_int && !dis_seen_q) begin
                stat_disables_q <= stat_disables_q + 32'd1;
            end
        end
    end

    always_comb begin
        bus.vp_stat_flushes  = stat_flushes_q;
        bus.vp_stat_disables = stat_disables_q;
    end
`endif

endmodule

// File: tb/tb_dec_vp_flush_arb.sv
// Scoreboard bench for dec_vp_flush_arb: stimulus pushes expected flush pulses,
// a negedge monitor pops and compares them; state outputs are checked directly.
module tb_dec_vp_flush_arb;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   n_push;
    logic saw_dis;

    typedef struct {
        logic [62:0] path;
        logic [63:0] result;
        logic        lane;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    dec_vp_flush_arb_if vif();

    dec_vp_flush_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every observed pulse must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && vif.vp_flush_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got path %0h lane %0d expected none (cycle %0d)",
                         vif.vp_flush_path, vif.vp_flush_lane, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_path",   {1'b0, vif.vp_flush_path}, {1'b0, e.path});
                chk("pulse_result", vif.vp_flush_result, e.result);
                chk("pulse_lane",   {63'd0, vif.vp_flush_lane}, {63'd0, e.lane});
                chk("pulse_cycle",  64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        saw_dis = saw_dis | vif.vp_disable;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [62:0] p, input logic [63:0] r, input logic l, input int c);
        exp_t e;
        e.path = p; e.result = r; e.lane = l; e.cyc = c;
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic clr_req();
        vif.i0_vp_req = 1'b0;
        vif.i1_vp_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        n_push = 0;
        step();
    endtask

    // One i0 flush episode: request, pulse next cycle, then wait until idle again.
    task automatic i0_episode(input logic [62:0] p, input logic [63:0] r);
        vif.i0_vp_req = 1'b1; vif.i0_vp_path = p; vif.i0_vp_actual = r;
        push(p, r, 1'b0, cyc + 1);
        step();
        clr_req();
        steps(5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        checks = 0; errors = 0; n_push = 0; saw_dis = 1'b0;
        cyc = 0;
        vif.freeze = 1'b0; vif.ext_flush = 1'b0;
        vif.i0_vp_req = 1'b0; vif.i0_vp_path = '0; vif.i0_vp_actual = '0;
        vif.i1_vp_req = 1'b0; vif.i1_vp_path = '0; vif.i1_vp_actual = '0;
        do_reset();

        // Reset state
        chk("rst_valid",   {63'd0, vif.vp_flush_valid}, 64'd0);
        chk("rst_busy",    {63'd0, vif.vp_busy},        64'd0);
        chk("rst_disable", {63'd0, vif.vp_disable},     64'd0);
        chk("rst_path",    {1'b0, vif.vp_flush_path},   64'd0);

        // 1: single i0 flush, busy for FLUSH + 4 RECOVER cycles
        vif.i0_vp_req = 1'b1; vif.i0_vp_path = 63'h100; vif.i0_vp_actual = 64'hAB;
        push(63'h100, 64'hAB, 1'b0, cyc + 1);
        step();
        clr_req();
        for (int k = 0; k < 5; k++) begin
            chk("t1_busy", {63'd0, vif.vp_busy}, 64'd1);
            step();
        end
        chk("t1_idle", {63'd0, vif.vp_busy}, 64'd0);
        steps(2);

        // 2: both lanes request, only i0 pulses
        vif.i0_vp_req = 1'b1; vif.i0_vp_path = 63'h300; vif.i0_vp_actual = 64'h11;
        vif.i1_vp_req = 1'b1; vif.i1_vp_path = 63'h200; vif.i1_vp_actual = 64'h22;
        push(63'h300, 64'h11, 1'b0, cyc + 1);
        step();
        clr_req();
        steps(8);

        // 3: ext_flush masks the pulse, then an i1 request is accepted
        vif.i1_vp_req = 1'b1; vif.i1_vp_path = 63'h400; vif.i1_vp_actual = 64'h33;
        step();
        clr_req();
        vif.ext_flush = 1'b1;
        #1;
        chk("t3_masked", {63'd0, vif.vp_flush_valid}, 64'd0);
        step();
        vif.ext_flush = 1'b0;
        chk("t3_idle", {63'd0, vif.vp_busy}, 64'd0);
        vif.i1_vp_req = 1'b1; vif.i1_vp_path = 63'h500; vif.i1_vp_actual = 64'h44;
        push(63'h500, 64'h44, 1'b1, cyc + 1);
        step();
        clr_req();
        steps(6);

        // 4: request during RECOVER is dropped; next idle request accepted
        vif.i0_vp_req = 1'b1; vif.i0_vp_path = 63'h600; vif.i0_vp_actual = 64'h55;
        push(63'h600, 64'h55, 1'b0, cyc + 1);
        step();
        clr_req();
        step();
        vif.i1_vp_req = 1'b1; vif.i1_vp_path = 63'h700; vif.i1_vp_actual = 64'h66;
        step();
        clr_req();
        steps(3);
        chk("t4_idle", {63'd0, vif.vp_busy}, 64'd0);
        vif.i0_vp_req = 1'b1; vif.i0_vp_path = 63'h800; vif.i0_vp_actual = 64'h77;
        push(63'h800, 64'h77, 1'b0, cyc + 1);
        step();
        clr_req();
        steps(6);

        // 6: freeze during FLUSH delays the pulse until freeze drops
        vif.i0_vp_req = 1'b1; vif.i0_vp_path = 63'h900; vif.i0_vp_actual = 64'h88;
        push(63'h900, 64'h88, 1'b0, cyc + 4);
        step();
        clr_req();
        vif.freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t6_frz_valid", {63'd0, vif.vp_flush_valid}, 64'd0);
            chk("t6_frz_busy",  {63'd0, vif.vp_busy},        64'd1);
            step();
        end
        vif.freeze = 1'b0;
        steps(7);
        chk("t6_drain", 64'(exp_q.size()), 64'd0);

        // 5a: eight acceptances inside one window -> vp_disable for 256 cycles
        do_reset();
        saw_dis = 1'b0;
        for (int k = 0; k < 7; k++) i0_episode(63'h1000 + 63'(k), 64'(k));
        chk("t5_no_early_dis", {63'd0, saw_dis}, 64'd0);
        vif.i0_vp_req = 1'b1; vif.i0_vp_path = 63'h1007; vif.i0_vp_actual = 64'h7;
        push(63'h1007, 64'h7, 1'b0, cyc + 1);
        step();
        clr_req();
        chk("t5_dis_set", {63'd0, vif.vp_disable}, 64'd1);
        hi = 0;
        while (vif.vp_disable === 1'b1 && hi < 1000) begin
            hi++;
            step();
        end
        chk("t5_dis_len", 64'(hi), 64'd256);

        // 5b: seven acceptances, window wrap, one more -> no disable
        saw_dis = 1'b0;
        for (int k = 0; k < 7; k++) i0_episode(63'h2000 + 63'(k), 64'h100 + 64'(k));
        steps(40);
        i0_episode(63'h2100, 64'h200);
        steps(4);
        chk("t5_wrap_no_dis", {63'd0, saw_dis}, 64'd0);
        chk("t5_drain", 64'(exp_q.size()), 64'd0);

`ifdef DEC_VP_FLUSH_STATS_EN
        chk("stat_flushes",  {32'd0, vif.vp_stat_flushes},  64'(n_push));
        chk("stat_disables", {32'd0, vif.vp_stat_disables}, 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
